// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg: shared constants and helpers for the stream multiplexer.
//   MODE_FIXED / MODE_RR : values of the mode input
//   XFER_CNT_W           : width of the optional transfer counter
//   rr_idx()             : channel index reached k steps after base, modulo n
package stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;
  localparam int   XFER_CNT_W = 16;

  function automatic int rr_idx(input int base, input int k, input int n);
    return (base + k) % n;
  endfunction

endpackage

// File: rtl/stream_mux_if.sv
// stream_mux_if: input/output stream bundle of stream_mux.
//   in_data/in_valid/in_ready : CHANNELS source streams, channel i at [i*WIDTH +: WIDTH]
//   sel/mode                  : channel select (fixed mode) and arbitration mode
//   out_data/out_chan/out_valid/out_ready : registered output stream
// Modports: master = sources + sink side, slave = the multiplexer.
interface stream_mux_if #(
  parameter int WIDTH    = 2,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
);
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [SEL_W-1:0]          sel;
  logic                      mode;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_chan;
  logic                      out_valid;
  logic                      out_ready;

  modport master (
    output in_data, in_valid, sel, mode, out_ready,
    input  in_ready, out_data, out_chan, out_valid
  );

  modport slave (
    input  in_data, in_valid, sel, mode, out_ready,
    output in_ready, out_data, out_chan, out_valid
  );
endinterface

// File: rtl/stream_mux_rr_arbiter.sv
// rr_arbiter: combinational round-robin search.
//   req_i       : per-channel request
//   ptr_i       : last granted channel; search starts at ptr_i+1 and wraps
//   enable_i    : when low no grant is issued
//   gnt_valid_o : a channel was found
//   gnt_idx_o   : index of the granted channel (0 when none)
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic [CHANNELS-1:0] req_i,
  input  logic [SEL_W-1:0]    ptr_i,
  input  logic                enable_i,
  output logic                gnt_valid_o,
  output logic [SEL_W-1:0]    gnt_idx_o
);

  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    if (enable_i) begin
      // k = CHANNELS lands back on ptr itself, so the last granted channel
      // is still picked when it is the only requester.
      for (int k = 1; k <= CHANNELS; k++) begin
        if (!gnt_valid_o && req_i[rr_idx(int'(ptr_i), k, CHANNELS)]) begin
          gnt_valid_o = 1'b1;
          gnt_idx_o   = SEL_W'(rr_idx(int'(ptr_i), k, CHANNELS));
        end
      end
    end
  end

endmodule

// File: rtl/stream_mux.sv
// stream_mux: registered N-channel stream multiplexer with valid/ready on every
// input and on the output. One word per cycle is picked by explicit select
// (mode=0) or round-robin (mode=1) and held in a single-entry output register.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : stream_mux_if.slave (inputs, select, mode, output stream)
//   xfer_cnt : accepted-output count, only with STREAM_MUX_STATS_EN defined
// Optional feature macro: STREAM_MUX_STATS_EN.
module stream_mux
  import stream_mux_pkg::*;
#(
  parameter int WIDTH    = 2,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic              clk,
  input  logic              rst,
  stream_mux_if.slave       bus
`ifdef STREAM_MUX_STATS_EN
  ,
  output logic [XFER_CNT_W-1:0] xfer_cnt
`endif
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_chan_q, out_chan_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic             load, mode_rr, fix_valid;
  logic             arb_valid;
  logic [SEL_W-1:0] arb_idx;
  logic             gnt_valid;
  logic [SEL_W-1:0] gnt_idx;
  logic [WIDTH-1:0] gnt_data;

  assign mode_rr = (bus.mode == MODE_RR);
  // Reset forces load low so nothing is accepted during the reset cycle.
  assign load    = !rst && (!out_valid_q || bus.out_ready);

  rr_arbiter #(.CHANNELS(CHANNELS), .SEL_W(SEL_W)) u_arb (
    .req_i       (bus.in_valid),
    .ptr_i       (ptr_q),
    .enable_i    (load && mode_rr),
    .gnt_valid_o (arb_valid),
    .gnt_idx_o   (arb_idx)
  );

  // Compare against every legal index so an out-of-range sel simply never matches.
  always_comb begin
    fix_valid = 1'b0;
    for (int i = 0; i < CHANNELS; i++)
      if (bus.sel == SEL_W'(i) && bus.in_valid[i]) fix_valid = 1'b1;
  end

  assign gnt_valid = load && (mode_rr ? arb_valid : fix_valid);
  assign gnt_idx   = mode_rr ? arb_idx : bus.sel;

  always_comb begin
    bus.in_ready = '0;
    gnt_data     = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (gnt_valid && gnt_idx == SEL_W'(i)) bus.in_ready[i] = 1'b1;
      if (gnt_idx == SEL_W'(i)) gnt_data = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    ptr_d       = ptr_q;
    if (gnt_valid) begin
      // Drain and refill in one cycle: no bubble.
      out_valid_d = 1'b1;
      out_data_d  = gnt_data;
      out_chan_d  = gnt_idx;
      if (mode_rr) ptr_d = gnt_idx;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      ptr_q       <= SEL_W'(CHANNELS - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_chan  = out_chan_q;

`ifdef STREAM_MUX_STATS_EN
  logic [XFER_CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst)                              cnt_q <= '0;
    else if (out_valid_q && bus.out_ready) cnt_q <= cnt_q + 1'b1;
  end

  assign xfer_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_stream_mux.sv
// tb_stream_mux: directed-vector bench for stream_mux.
// DUT a: 4 channels; DUT b: 3 channels (out-of-range select and modulo-3 wrap).
module tb_stream_mux;
  import stream_mux_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stream_mux_if #(.WIDTH(2), .CHANNELS(4), .SEL_W(2)) ifa ();
  stream_mux_if #(.WIDTH(2), .CHANNELS(3), .SEL_W(2)) ifb ();

`ifdef STREAM_MUX_STATS_EN
  logic [XFER_CNT_W-1:0] cnt_a, cnt_b;
`endif

  stream_mux #(.WIDTH(2), .CHANNELS(4), .SEL_W(2)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa)
`ifdef STREAM_MUX_STATS_EN
    , .xfer_cnt(cnt_a)
`endif
  );

  stream_mux #(.WIDTH(2), .CHANNELS(3), .SEL_W(2)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb)
`ifdef STREAM_MUX_STATS_EN
    , .xfer_cnt(cnt_b)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Land 1 time unit after the rising edge; inputs change here, outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic v, input logic [1:0] d, input logic [1:0] c);
    chk({tag, ".vld"},  ifa.out_valid, v);
    chk({tag, ".data"}, ifa.out_data,  d);
    chk({tag, ".chan"}, ifa.out_chan,  c);
  endtask

  initial begin
    logic [1:0] rr_a [6];
    logic [1:0] rr_b [3];
    rr_a = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
    rr_b = '{2'd0, 2'd2, 2'd0};

    // Reset with every input active.
    ifa.in_data = 8'b01_10_11_00;  // ch3=01 ch2=10 ch1=11 ch0=00
    ifa.in_valid = 4'b1111;
    ifa.sel = 2'd2;
    ifa.mode = MODE_RR;
    ifa.out_ready = 1'b1;
    ifb.in_data = 6'b01_11_10;     // ch2=01 ch1=11 ch0=10
    ifb.in_valid = 3'b000;
    ifb.sel = 2'd0;
    ifb.mode = MODE_FIXED;
    ifb.out_ready = 1'b1;
    #1;
    chk("rst.rdy0", ifa.in_ready, 4'b0000);
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst.rdy", ifa.in_ready, 4'b0000);
      chk_a("rst", 1'b0, 2'b00, 2'd0);
    end

    // Fixed mode, sel=2.
    rst = 1'b0;
    ifa.mode = MODE_FIXED;
    #1;
    chk("fix.rdy", ifa.in_ready, 4'b0100);
    tick();
    chk_a("fix", 1'b1, 2'b10, 2'd2);

    // Round-robin from reset pointer (fixed grant left ptr at 3).
    ifa.mode = MODE_RR;
    ifa.in_valid = 4'b1011;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rr.rdy", ifa.in_ready, 32'(1) << rr_a[k]);
      tick();
      chk_a("rr", 1'b1, ifa.in_data[rr_a[k]*2 +: 2], rr_a[k]);
    end

    // Backpressure: register holds ch3 word 01.
    ifa.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp.rdy", ifa.in_ready, 4'b0000);
      tick();
      chk_a("bp", 1'b1, 2'b01, 2'd3);
    end
    ifa.out_ready = 1'b1;
    #1;
    chk("bp.rel.rdy", ifa.in_ready, 4'b0001);
    tick();
    chk_a("bp.rel", 1'b1, 2'b00, 2'd0);

    // Drain with no requesters, then resume round-robin after ch0.
    ifa.in_valid = 4'b0000;
    #1;
    chk("drain.rdy", ifa.in_ready, 4'b0000);
    tick();
    chk("drain.vld", ifa.out_valid, 1'b0);
    ifa.in_valid = 4'b1111;
    #1;
    chk("resume.rdy", ifa.in_ready, 4'b0010);
    tick();
    chk_a("resume", 1'b1, 2'b11, 2'd1);

    // Fixed select of an idle channel: no grant.
    ifa.mode = MODE_FIXED;
    ifa.sel = 2'd3;
    ifa.in_valid = 4'b0111;
    #1;
    chk("fixidle.rdy", ifa.in_ready, 4'b0000);
    tick();
    chk("fixidle.vld", ifa.out_valid, 1'b0);

    // Reset mid-operation with a full register.
    ifa.sel = 2'd1;
    tick();
    chk_a("pre.mrst", 1'b1, 2'b11, 2'd1);
    rst = 1'b1;
    ifa.mode = MODE_RR;
    ifa.in_valid = 4'b1111;
    #1;
    chk("mrst.rdy", ifa.in_ready, 4'b0000);
    tick();
    chk_a("mrst", 1'b0, 2'b00, 2'd0);
    rst = 1'b0;
    #1;
    chk("mrst.ptr.rdy", ifa.in_ready, 4'b0001);
    tick();
    chk_a("mrst.ptr", 1'b1, 2'b00, 2'd0);
    ifa.in_valid = 4'b0000;
    tick();

    // 3-channel DUT: valid select, then sel=3 (out of range).
    ifb.sel = 2'd1;
    ifb.in_valid = 3'b111;
    #1;
    chk("b.fix.rdy", ifb.in_ready, 3'b010);
    tick();
    chk("b.fix.vld", ifb.out_valid, 1'b1);
    chk("b.fix.data", ifb.out_data, 2'b11);
    chk("b.fix.chan", ifb.out_chan, 2'd1);
    ifb.sel = 2'd3;
    #1;
    chk("b.oor.rdy", ifb.in_ready, 3'b000);
    tick();
    chk("b.oor.vld", ifb.out_valid, 1'b0);

    // 3-channel round-robin wraps modulo 3, skipping idle ch1.
    ifb.mode = MODE_RR;
    ifb.in_valid = 3'b101;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("b.rr.rdy", ifb.in_ready, 32'(1) << rr_b[k]);
      tick();
      chk("b.rr.chan", ifb.out_chan, rr_b[k]);
      chk("b.rr.data", ifb.out_data, ifb.in_data[rr_b[k]*2 +: 2]);
    end
    ifb.in_valid = 3'b000;

`ifdef STREAM_MUX_STATS_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("cnt.rst", cnt_a, 16'd0);
    ifa.mode = MODE_FIXED;
    ifa.sel = 2'd0;
    ifa.in_valid = 4'b0001;
    ifa.out_ready = 1'b1;
    // First edge only loads; every later edge accepts one word.
    repeat (65537) tick();
    chk("cnt.full", cnt_a, 16'd0);
    tick();
    chk("cnt.wrap", cnt_a, 16'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
